// File: rtl/mcp_main_ctrl_if.sv
// Control/status bundle between the multicycle main controller and the datapath.
// The master side is the controller; the slave side is the datapath (or a bench).
interface mcp_main_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr_i32;
  logic             zero_i;
  logic             pc_we_o;
  logic [1:0]       pc_branch_o2;
  logic             instr_or_data_o;
  logic             instr_we_o;
  logic             reg_dst_rtrd_o;
  logic             mem_to_reg_o;
  logic             enable_wrf_o;
  logic             a_alu_input_o;
  logic [1:0]       b_alu_input_o2;
  logic [1:0]       alu_alt_ctrl_o2;
  logic             mem_we_o;
  logic [CNT_W-1:0] instr_count_o;
  logic             illegal_o;

  modport master (
    input  instr_i32, zero_i,
    output pc_we_o, pc_branch_o2, instr_or_data_o, instr_we_o, reg_dst_rtrd_o,
           mem_to_reg_o, enable_wrf_o, a_alu_input_o, b_alu_input_o2,
           alu_alt_ctrl_o2, mem_we_o, instr_count_o, illegal_o
  );

  modport slave (
    output instr_i32, zero_i,
    input  pc_we_o, pc_branch_o2, instr_or_data_o, instr_we_o, reg_dst_rtrd_o,
           mem_to_reg_o, enable_wrf_o, a_alu_input_o, b_alu_input_o2,
           alu_alt_ctrl_o2, mem_we_o, instr_count_o, illegal_o
  );
endinterface

// File: rtl/mcp_main_ctrl.sv
// Multicycle Moore main controller: decodes the IR opcode and sequences the datapath,
// counting retired instructions and flagging unsupported opcodes.
module mcp_main_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mcp_main_ctrl_if.master   bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t           state, next;
  logic [5:0]       opcode;
  logic             pc_write, branch, retire, bad_op;
  logic [1:0]       pc_branch, b_sel, alu_op;
  logic             instr_or_data, instr_we, reg_dst, mem_to_reg, enable_wrf, a_sel, mem_we;
  logic [CNT_W-1:0] instr_count;
  logic             illegal;

  assign opcode = bus.instr_i32[31:26];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= FETCH;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      state <= next;
      if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (bad_op) illegal <= 1'b1;
    end
  end

  always_comb begin
    next          = FETCH;
    pc_write      = 1'b0;
    branch        = 1'b0;
    retire        = 1'b0;
    bad_op        = 1'b0;
    pc_branch     = 2'b00;
    b_sel         = 2'b00;
    alu_op        = 2'b00;
    instr_or_data = 1'b0;
    instr_we      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    enable_wrf    = 1'b0;
    a_sel         = 1'b0;
    mem_we        = 1'b0;
    case (state)
      FETCH: begin
        instr_we = 1'b1;
        b_sel    = 2'b01;
        pc_write = 1'b1;
        next     = DECODE;
      end
      DECODE: begin
        // precompute the branch target into ALUOut while the opcode is decoded
        b_sel = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = EXECUTE;
          OP_BEQ:       next = BRANCH;
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JUMP;
          default: begin
            next   = FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        a_sel = 1'b1;
        b_sel = 2'b10;
        if (opcode == OP_LW)      next = MEMRD;
        else if (opcode == OP_SW) next = MEMWR;
        else                      next = FETCH;
      end
      MEMRD: begin
        instr_or_data = 1'b1;
        next          = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        enable_wrf = 1'b1;
        retire     = 1'b1;
      end
      MEMWR: begin
        instr_or_data = 1'b1;
        mem_we        = 1'b1;
        retire        = 1'b1;
      end
      EXECUTE: begin
        a_sel  = 1'b1;
        alu_op = 2'b10;
        next   = ALUWB;
      end
      ALUWB: begin
        reg_dst    = 1'b1;
        enable_wrf = 1'b1;
        retire     = 1'b1;
      end
      BRANCH: begin
        a_sel     = 1'b1;
        alu_op    = 2'b01;
        pc_branch = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      ADDIEX: begin
        a_sel  = 1'b1;
        b_sel  = 2'b10;
        next   = ADDIWB;
      end
      ADDIWB: begin
        enable_wrf = 1'b1;
        retire     = 1'b1;
      end
      JUMP: begin
        pc_branch = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      default: next = FETCH;
    endcase
  end

  assign bus.pc_we_o         = pc_write | (branch & bus.zero_i);
  assign bus.pc_branch_o2    = pc_branch;
  assign bus.instr_or_data_o = instr_or_data;
  assign bus.instr_we_o      = instr_we;
  assign bus.reg_dst_rtrd_o  = reg_dst;
  assign bus.mem_to_reg_o    = mem_to_reg;
  assign bus.enable_wrf_o    = enable_wrf;
  assign bus.a_alu_input_o   = a_sel;
  assign bus.b_alu_input_o2  = b_sel;
  assign bus.alu_alt_ctrl_o2 = alu_op;
  assign bus.mem_we_o        = mem_we;
  assign bus.instr_count_o   = instr_count;
  assign bus.illegal_o       = illegal;

endmodule

// File: tb/tb_mcp_main_ctrl.sv
// Bench for mcp_main_ctrl: directed instructions plus a random instruction stream,
// checked cycle by cycle against per-instruction step lists built from the state table.
module tb_mcp_main_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcp_main_ctrl_if #(.CNT_W(32)) bus ();
  mcp_main_ctrl_if #(.CNT_W(4))  bus4 ();

  mcp_main_ctrl #(.CNT_W(32)) dut  (.clk_i(clk), .reset_i(rst), .bus(bus.master));
  mcp_main_ctrl #(.CNT_W(4))  dut4 (.clk_i(clk), .reset_i(rst), .bus(bus4.master));

  assign bus4.instr_i32 = bus.instr_i32;
  assign bus4.zero_i    = bus.zero_i;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_branch;
    logic       iod;
    logic       iw;
    logic       reg_dst;
    logic       m2r;
    logic       wrf;
    logic       a;
    logic [1:0] b;
    logic [1:0] alt;
    logic       mw;
  } vec_t;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MWR = 5;
  localparam int P_EX = 6, P_AWB = 7, P_BR = 8, P_AEX = 9, P_AWBI = 10, P_J = 11;

  int          checks = 0;
  int          failures = 0;
  int unsigned model_count = 0;
  logic        model_ill = 1'b0;
  logic [5:0]  legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic vec_t exp_vec(input int ph, input logic z);
    vec_t v = '0;
    case (ph)
      P_F:    begin v.pc_we = 1'b1; v.iw = 1'b1; v.b = 2'b01; end
      P_D:    v.b = 2'b11;
      P_MA:   begin v.a = 1'b1; v.b = 2'b10; end
      P_MR:   v.iod = 1'b1;
      P_MWB:  begin v.m2r = 1'b1; v.wrf = 1'b1; end
      P_MWR:  begin v.iod = 1'b1; v.mw = 1'b1; end
      P_EX:   begin v.a = 1'b1; v.alt = 2'b10; end
      P_AWB:  begin v.reg_dst = 1'b1; v.wrf = 1'b1; end
      P_BR:   begin v.a = 1'b1; v.alt = 2'b01; v.pc_branch = 2'b01; v.pc_we = z; end
      P_AEX:  begin v.a = 1'b1; v.b = 2'b10; end
      P_AWBI: v.wrf = 1'b1;
      P_J:    begin v.pc_branch = 2'b10; v.pc_we = 1'b1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic vec_t obs_vec();
    vec_t v;
    v.pc_we     = bus.pc_we_o;
    v.pc_branch = bus.pc_branch_o2;
    v.iod       = bus.instr_or_data_o;
    v.iw        = bus.instr_we_o;
    v.reg_dst   = bus.reg_dst_rtrd_o;
    v.m2r       = bus.mem_to_reg_o;
    v.wrf       = bus.enable_wrf_o;
    v.a         = bus.a_alu_input_o;
    v.b         = bus.b_alu_input_o2;
    v.alt       = bus.alu_alt_ctrl_o2;
    v.mw        = bus.mem_we_o;
    return v;
  endfunction

  task automatic steps_for(input logic [5:0] op, output int ph[5], output int n);
    ph = '{P_F, P_D, 0, 0, 0};
    n  = 2;
    case (op)
      6'h23: begin ph[2] = P_MA; ph[3] = P_MR;   ph[4] = P_MWB; n = 5; end
      6'h2B: begin ph[2] = P_MA; ph[3] = P_MWR;  n = 4; end
      6'h00: begin ph[2] = P_EX; ph[3] = P_AWB;  n = 4; end
      6'h08: begin ph[2] = P_AEX; ph[3] = P_AWBI; n = 4; end
      6'h04: begin ph[2] = P_BR; n = 3; end
      6'h02: begin ph[2] = P_J;  n = 3; end
      default: n = 2;
    endcase
  endtask

  task automatic check_status(input string tag);
    chk({tag, " count"},   bus.instr_count_o, model_count);
    chk({tag, " count4"},  {28'd0, bus4.instr_count_o}, model_count % 16);
    chk({tag, " illegal"}, {31'd0, bus.illegal_o}, {31'd0, model_ill});
  endtask

  // Call one cycle into the FETCH state (#1 after its posedge); returns likewise.
  task automatic do_instr(input logic [31:0] ins, input int zmode);
    int ph[5];
    int n;
    bus.instr_i32 = ins;
    steps_for(ins[31:26], ph, n);
    for (int i = 0; i < n; i++) begin
      bus.zero_i = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      @(negedge clk);
      chk($sformatf("vec op=%02h step=%0d", ins[31:26], i), 32'(obs_vec()),
          32'(exp_vec(ph[i], bus.zero_i)));
      @(posedge clk);
      #1;
    end
    if (n == 2) model_ill = 1'b1;
    else        model_count++;
    check_status($sformatf("after op=%02h", ins[31:26]));
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_illegal);
    logic [5:0] op;
    if (allow_illegal && $urandom_range(0, 5) == 0) begin
      do begin
        op = 6'($urandom_range(0, 63));
      end while (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02});
    end else begin
      op = legal_ops[$urandom_range(0, 5)];
    end
    return {op, 26'($urandom)};
  endfunction

  initial begin
    bus.instr_i32 = 32'h0;
    bus.zero_i    = 1'b0;
    #2;
    chk("reset vec", 32'(obs_vec()), 32'(exp_vec(P_F, 1'b0)));
    check_status("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    do_instr(32'h8C080004, 2);   // lw
    do_instr(32'h11090003, 1);   // beq taken
    do_instr(32'h11090003, 0);   // beq not taken
    do_instr(32'h01095020, 2);   // add
    do_instr(32'hAC080008, 2);   // sw
    do_instr(32'h08000010, 2);   // j
    do_instr(32'hFC000000, 2);   // opcode 0x3F
    do_instr(32'h08000010, 2);

    // reset in the middle of MEMRD
    bus.instr_i32 = 32'h8C080004;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("memrd vec", 32'(obs_vec()), 32'(exp_vec(P_MR, 1'b0)));
    #1 rst = 1'b1;
    #1;
    model_count = 0;
    model_ill   = 1'b0;
    chk("midreset vec", 32'(obs_vec()), 32'(exp_vec(P_F, 1'b0)));
    check_status("midreset");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) do_instr(rand_instr(1'b0), 2);
    chk("wrap16 count4", {28'd0, bus4.instr_count_o}, 32'd0);

    for (int i = 0; i < 30; i++) do_instr(rand_instr(1'b1), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
